// File: rtl/fir_stream_bridge_pkg.sv
// Shared constants and types for the FIR stream bridge.
// Holds the sample width, the counter width and the bridge state encoding.
package fir_stream_bridge_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    ARM   = 2'd2,
    RUN   = 2'd3
  } state_t;

  // Counter increment that holds at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fir_stream_bridge_fifo.sv
// First-word-fall-through synchronous FIFO (module sync_fifo).
// Push on full is taken only when a pop frees the slot in the same cycle; pop on empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign dout    = mem[rd_ptr_reg[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/fir_stream_bridge.sv
// Valid/ready adapter around the folded 12-tap FIR: ingress FIFO feeds fir_din on
// sample_in strobes, egress FIFO captures fir_dout on sample_out strobes.
module fir_stream_bridge
  import fir_stream_bridge_pkg::*;
#(
  parameter int IN_DEPTH    = 8,
  parameter int OUT_DEPTH   = 4,
  parameter int PRIME_LEVEL = 2,
  parameter int DROP_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  fir_en,
  output logic [DATA_WIDTH-1:0] fir_din,
  input  logic                  fir_sample_in,
  input  logic [DATA_WIDTH-1:0] fir_dout,
  input  logic                  fir_sample_out,
  output logic                  running,
  output logic [CNT_WIDTH-1:0]  underflow_cnt,
  output logic [CNT_WIDTH-1:0]  overflow_cnt
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam logic [IAW:0] PRIME_CNT = PRIME_LEVEL[IAW:0];
  localparam logic [7:0]   DROP_INIT = DROP_FIRST[7:0];

  state_t                 state_reg, state_next;
  logic                   fir_en_reg;
  logic [7:0]             drop_reg;
  logic [CNT_WIDTH-1:0]   underflow_reg;
  logic [CNT_WIDTH-1:0]   overflow_reg;

  logic                   in_push, in_pop, in_full, in_empty;
  logic [DATA_WIDTH-1:0]  in_head;
  logic [IAW:0]           in_count;
  logic                   out_push, out_pop, out_full, out_empty;
  logic [DATA_WIDTH-1:0]  out_head;
  logic [OAW:0]           out_count;
  logic                   unused_out_count;

  logic                   is_run;
  logic                   capture;
  logic                   drop_active;
  logic                   underflow_hit;
  logic                   overflow_hit;

  assign is_run        = (state_reg == RUN);
  assign running       = is_run;
  assign fir_en        = fir_en_reg;
  assign underflow_cnt = underflow_reg;
  assign overflow_cnt  = overflow_reg;

  // Ingress: s_ready depends on registered fullness only, never on a same-cycle pop.
  assign s_ready       = !in_full;
  assign in_push       = s_valid && !in_full;
  assign in_pop        = fir_sample_in && is_run && !in_empty;
  assign underflow_hit = fir_sample_in && is_run && in_empty;
  assign fir_din       = in_pop ? in_head : '0;

  // Egress: a downstream pop in the same cycle frees a slot for the capture.
  assign capture       = fir_sample_out && is_run;
  assign drop_active   = (drop_reg != 8'd0);
  assign out_pop       = !out_empty && m_ready;
  assign out_push      = capture && !drop_active && (!out_full || out_pop);
  assign overflow_hit  = capture && !drop_active && out_full && !out_pop;
  assign m_valid       = !out_empty;
  assign m_data        = out_empty ? '0 : out_head;
  assign unused_out_count = ^out_count;

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_push),
    .pop   (in_pop),
    .din   (s_data),
    .dout  (in_head),
    .full  (in_full),
    .empty (in_empty),
    .count (in_count)
  );

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (out_push),
    .pop   (out_pop),
    .din   (fir_dout),
    .dout  (out_head),
    .full  (out_full),
    .empty (out_empty),
    .count (out_count)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (go) state_next = PRIME;
      PRIME: begin
        if (!go)                        state_next = IDLE;
        else if (in_count >= PRIME_CNT) state_next = ARM;
      end
      ARM:     state_next = RUN;
      RUN:     state_next = RUN;  // the FIR cannot be stopped once started
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      fir_en_reg    <= 1'b0;
      drop_reg      <= DROP_INIT;
      underflow_reg <= '0;
      overflow_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      fir_en_reg <= (state_next == ARM);
      if (capture && drop_active) drop_reg      <= drop_reg - 8'd1;
      if (underflow_hit)          underflow_reg <= sat_inc(underflow_reg);
      if (overflow_hit)           overflow_reg  <= sat_inc(overflow_reg);
    end
  end

endmodule

// File: tb/tb_fir_stream_bridge.sv
// Self-checking bench for fir_stream_bridge; FIR strobes are modelled by hand and
// egress results are checked against a queue of expected samples.
module tb_fir_stream_bridge;
  import fir_stream_bridge_pkg::*;

  localparam int OUT_DEPTH  = 4;
  localparam int DROP_FIRST = 1;

  logic                  clk;
  logic                  rst;
  logic                  go;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  fir_en;
  logic [DATA_WIDTH-1:0] fir_din;
  logic                  fir_sample_in;
  logic [DATA_WIDTH-1:0] fir_dout;
  logic                  fir_sample_out;
  logic                  running;
  logic [CNT_WIDTH-1:0]  underflow_cnt;
  logic [CNT_WIDTH-1:0]  overflow_cnt;

  int checks = 0;
  int errors = 0;
  logic [DATA_WIDTH-1:0] sb [$];
  int model_cnt;
  int model_drop;
  int model_ovf;

  fir_stream_bridge #(
    .IN_DEPTH(8), .OUT_DEPTH(OUT_DEPTH), .PRIME_LEVEL(2), .DROP_FIRST(DROP_FIRST)
  ) dut (
    .clk(clk), .rst(rst), .go(go),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .fir_en(fir_en), .fir_din(fir_din), .fir_sample_in(fir_sample_in),
    .fir_dout(fir_dout), .fir_sample_out(fir_sample_out),
    .running(running), .underflow_cnt(underflow_cnt), .overflow_cnt(overflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; go = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    fir_sample_in = 1'b0; fir_sample_out = 1'b0; fir_dout = '0;
    step; step;
    rst = 1'b0;
    step;
    sb.delete();
    model_cnt = 0; model_drop = DROP_FIRST; model_ovf = 0;
  endtask

  task automatic push_in(input logic [DATA_WIDTH-1:0] v);
    s_valid = 1'b1; s_data = v;
    step;
    s_valid = 1'b0;
  endtask

  task automatic wait_running;
    int k = 0;
    while (running !== 1'b1 && k < 20) begin step; k++; end
    chk("wait_running", {31'd0, running}, 32'd1);
  endtask

  task automatic arm_run(input int n, input logic [DATA_WIDTH-1:0] base);
    do_reset;
    go = 1'b1;
    for (int i = 0; i < n; i++) push_in(base + DATA_WIDTH'(i));
    wait_running;
  endtask

  // One FIR sample_in strobe, checking the sample the bridge supplies.
  task automatic fir_in(input string name, input logic [DATA_WIDTH-1:0] exp);
    fir_sample_in = 1'b1;
    #1;
    chk(name, {16'd0, fir_din}, {16'd0, exp});
    step;
    fir_sample_in = 1'b0;
  endtask

  // One FIR sample_out strobe; the model decides drop / store / overflow.
  task automatic fir_out(input logic [DATA_WIDTH-1:0] v);
    bit pop_now, full_now;
    logic [DATA_WIDTH-1:0] e;
    fir_sample_out = 1'b1; fir_dout = v;
    pop_now  = m_ready && (model_cnt > 0);
    full_now = (model_cnt == OUT_DEPTH);
    if (pop_now) begin
      #1;
      e = sb.pop_front();
      chk("m_data_on_pop", {16'd0, m_data}, {16'd0, e});
      model_cnt--;
    end
    if (model_drop > 0) model_drop--;
    else if (!full_now || pop_now) begin sb.push_back(v); model_cnt++; end
    else model_ovf++;
    step;
    fir_sample_out = 1'b0;
  endtask

  task automatic drain(input int n);
    logic [DATA_WIDTH-1:0] e;
    m_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      chk("drain_valid", {31'd0, m_valid}, 32'd1);
      chk("drain_data", {16'd0, m_data}, {16'd0, e});
      if (model_cnt > 0) model_cnt--;
      step;
    end
    m_ready = 1'b0;
    #1;
    chk("drain_empty", {31'd0, m_valid}, 32'd0);
  endtask

  task automatic test_reset;
    rst = 1'b1; go = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    fir_sample_in = 1'b0; fir_sample_out = 1'b0; fir_dout = '0;
    #1;
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", {16'd0, m_data}, 32'd0);
    chk("rst_fir_en", {31'd0, fir_en}, 32'd0);
    chk("rst_fir_din", {16'd0, fir_din}, 32'd0);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_underflow", {16'd0, underflow_cnt}, 32'd0);
    chk("rst_overflow", {16'd0, overflow_cnt}, 32'd0);
  endtask

  task automatic test_priming;
    do_reset;
    go = 1'b1; s_valid = 1'b1; s_data = 16'h0100; fir_sample_in = 1'b1;
    step;
    #1;
    chk("prime_strobe_ignored", {16'd0, fir_din}, 32'd0);
    s_data = 16'h0200;
    step;
    s_valid = 1'b0; fir_sample_in = 1'b0;
    #1;
    chk("prime_no_en_yet", {31'd0, fir_en}, 32'd0);
    step;
    chk("prime_fir_en", {31'd0, fir_en}, 32'd1);
    chk("prime_not_running", {31'd0, running}, 32'd0);
    step;
    chk("prime_en_pulse_end", {31'd0, fir_en}, 32'd0);
    chk("prime_running", {31'd0, running}, 32'd1);
    fir_in("prime_first_din", 16'h0100);
    repeat (12) step;
    chk("prime_idle_din", {16'd0, fir_din}, 32'd0);
    repeat (11) step;
    fir_in("prime_second_din", 16'h0200);
  endtask

  task automatic test_drop_first;
    arm_run(2, 16'h0A00);
    m_ready = 1'b0;
    fir_out(16'h1234);
    #1;
    chk("drop_first_no_valid", {31'd0, m_valid}, 32'd0);
    fir_out(16'h0042);
    chk("drop_second_valid", {31'd0, m_valid}, 32'd1);
    chk("drop_second_data", {16'd0, m_data}, 32'h0042);
    drain(1);
  endtask

  task automatic test_underflow;
    arm_run(2, 16'h0300);
    fir_in("uf_pre0", 16'h0300);
    fir_in("uf_pre1", 16'h0301);
    for (int i = 0; i < 3; i++) fir_in("uf_zero_din", 16'h0000);
    chk("uf_count3", {16'd0, underflow_cnt}, 32'd3);
    push_in(16'h0777);
    fir_in("uf_after_push", 16'h0777);
    chk("uf_count_hold", {16'd0, underflow_cnt}, 32'd3);
  endtask

  task automatic test_backpressure;
    arm_run(2, 16'h0400);
    m_ready = 1'b0;
    fir_out(16'h1234);
    for (int i = 1; i <= 5; i++) fir_out(16'h0011 * DATA_WIDTH'(i));
    chk("bp_overflow", {16'd0, overflow_cnt}, 32'd1);
    chk("bp_head", {16'd0, m_data}, 32'h0011);
    drain(4);
  endtask

  task automatic test_full_edge;
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) fir_out(16'h00A0 + DATA_WIDTH'(i));
    chk("fe_overflow_before", {16'd0, overflow_cnt}, 32'd1);
    m_ready = 1'b1;
    fir_out(16'h00A5);
    m_ready = 1'b0;
    #1;
    chk("fe_overflow_after", {16'd0, overflow_cnt}, 32'd1);
    drain(4);
  endtask

  task automatic test_ingress_full;
    do_reset;
    for (int i = 0; i < 8; i++) push_in(16'h0B00 + DATA_WIDTH'(i));
    #1;
    chk("inf_full_ready", {31'd0, s_ready}, 32'd0);
    s_valid = 1'b1; s_data = 16'hDEAD;
    step;
    chk("inf_blocked", {31'd0, s_ready}, 32'd0);
    s_data = 16'hBEEF;
    go = 1'b1;
    wait_running;
    fir_sample_in = 1'b1;
    #1;
    chk("inf_ready_on_pop", {31'd0, s_ready}, 32'd0);
    chk("inf_head", {16'd0, fir_din}, 32'h0B00);
    step;
    fir_sample_in = 1'b0;
    chk("inf_ready_after_pop", {31'd0, s_ready}, 32'd1);
    step;
    s_valid = 1'b0;
    chk("inf_full_again", {31'd0, s_ready}, 32'd0);
    for (int i = 1; i < 8; i++) fir_in("inf_order", 16'h0B00 + DATA_WIDTH'(i));
    fir_in("inf_wrapped", 16'hBEEF);
    fir_in("inf_empty", 16'h0000);
    chk("inf_underflow", {16'd0, underflow_cnt}, 32'd1);
  endtask

  task automatic test_reset_mid_run;
    arm_run(2, 16'h0C00);
    fir_in("mr_pre0", 16'h0C00);
    fir_in("mr_pre1", 16'h0C01);
    fir_in("mr_uf", 16'h0000);
    for (int i = 0; i < 3; i++) push_in(16'h0D00 + DATA_WIDTH'(i));
    fir_out(16'h1234);
    for (int i = 0; i < 5; i++) fir_out(16'h0E00 + DATA_WIDTH'(i));
    chk("mr_pre_valid", {31'd0, m_valid}, 32'd1);
    chk("mr_pre_overflow", {16'd0, overflow_cnt}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_running", {31'd0, running}, 32'd0);
    chk("mr_s_ready", {31'd0, s_ready}, 32'd1);
    chk("mr_m_valid", {31'd0, m_valid}, 32'd0);
    chk("mr_m_data", {16'd0, m_data}, 32'd0);
    chk("mr_underflow", {16'd0, underflow_cnt}, 32'd0);
    chk("mr_overflow", {16'd0, overflow_cnt}, 32'd0);
    step;
    chk("mr_fir_en", {31'd0, fir_en}, 32'd0);
    chk("mr_still_idle", {31'd0, running}, 32'd0);
    rst = 1'b0; go = 1'b0;
    step;
  endtask

  initial begin
    test_reset;
    test_priming;
    test_drop_first;
    test_underflow;
    test_backpressure;
    test_full_edge;
    test_ingress_full;
    test_reset_mid_run;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
